// File: rtl/pb_mcast_unroller.sv
// Multicast-to-unicast unroller: takes a base address plus a mask over the cluster X/Y fields
// and emits every covered unicast address, one per cycle, in ascending submask order.
module pb_mcast_unroller #(
  parameter int unsigned AddrWidth = 48,
  parameter int unsigned SelWidth  = 6,
  parameter int unsigned IdxWidth  = 12
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [AddrWidth-1:0] req_mask_i,
  input  logic [SelWidth-1:0]  req_mask_x_off_i,
  input  logic [SelWidth-1:0]  req_mask_x_len_i,
  input  logic [SelWidth-1:0]  req_mask_y_off_i,
  input  logic [SelWidth-1:0]  req_mask_y_len_i,
  output logic                 dst_valid_o,
  input  logic                 dst_ready_i,
  output logic [AddrWidth-1:0] dst_addr_o,
  output logic [IdxWidth-1:0]  dst_idx_o,
  output logic                 dst_last_o,
  output logic                 busy_o
);

  typedef enum logic {StIdle, StEmit} state_e;

  state_e                state_q, state_d;
  logic [AddrWidth-1:0]  field_mask, eff_mask;
  logic [AddrWidth-1:0]  base_q, mask_q, sub_q, sub_next;
  logic [IdxWidth-1:0]   idx_q;
  logic                  sub_last;

  // Field bits beyond AddrWidth simply never match a loop index and are dropped.
  always_comb begin
    field_mask = '0;
    for (int unsigned i = 0; i < AddrWidth; i++) begin
      field_mask[i] =
          ((i >= 32'(req_mask_x_off_i)) &&
           (i < 32'(req_mask_x_off_i) + 32'(req_mask_x_len_i))) ||
          ((i >= 32'(req_mask_y_off_i)) &&
           (i < 32'(req_mask_y_off_i) + 32'(req_mask_y_len_i)));
    end
  end

  assign eff_mask = req_mask_i & field_mask;
  assign sub_last = (sub_q == mask_q);
  // Filling the holes with ones lets the carry ripple straight to the next mask bit.
  assign sub_next = ((sub_q | ~mask_q) + AddrWidth'(1)) & mask_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (req_valid_i) state_d = StEmit;
      StEmit: if (dst_ready_i && sub_last) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready_o = 1'b0;
    dst_valid_o = 1'b0;
    busy_o      = 1'b0;
    dst_addr_o  = '0;
    dst_idx_o   = '0;
    dst_last_o  = 1'b0;
    unique case (state_q)
      StIdle: req_ready_o = 1'b1;
      StEmit: begin
        dst_valid_o = 1'b1;
        busy_o      = 1'b1;
        dst_addr_o  = base_q | sub_q;
        dst_idx_o   = idx_q;
        dst_last_o  = sub_last;
      end
      default: req_ready_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      base_q <= '0;
      mask_q <= '0;
      sub_q  <= '0;
      idx_q  <= '0;
    end else if (state_q == StIdle && req_valid_i) begin
      base_q <= req_addr_i & ~eff_mask;
      mask_q <= eff_mask;
      sub_q  <= '0;
      idx_q  <= '0;
    end else if (state_q == StEmit && dst_ready_i && !sub_last) begin
      sub_q <= sub_next;
      idx_q <= idx_q + IdxWidth'(1);
    end
  end

endmodule

// File: tb/tb_pb_mcast_unroller.sv
// Randomized self-checking bench for pb_mcast_unroller against a submask-enumeration model.
module tb_pb_mcast_unroller;

  localparam int unsigned AW = 48;
  localparam int unsigned SW = 6;
  localparam int unsigned IW = 12;

  typedef struct {
    logic [AW-1:0] addr;
    int            idx;
    bit            last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_addr = '0;
  logic [AW-1:0] req_mask = '0;
  logic [SW-1:0] x_off = '0, x_len = '0, y_off = '0, y_len = '0;
  logic          dst_valid;
  logic          dst_ready = 1'b0;
  logic [AW-1:0] dst_addr;
  logic [IW-1:0] dst_idx;
  logic          dst_last;
  logic          busy;

  int    errors = 0;
  int    checks = 0;
  beat_t exp_q[$];

  pb_mcast_unroller #(.AddrWidth(AW), .SelWidth(SW), .IdxWidth(IW)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .req_addr_i       (req_addr),
    .req_mask_i       (req_mask),
    .req_mask_x_off_i (x_off),
    .req_mask_x_len_i (x_len),
    .req_mask_y_off_i (y_off),
    .req_mask_y_len_i (y_len),
    .dst_valid_o      (dst_valid),
    .dst_ready_i      (dst_ready),
    .dst_addr_o       (dst_addr),
    .dst_idx_o        (dst_idx),
    .dst_last_o       (dst_last),
    .busy_o           (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: enumerate k = 0..2^n-1 and scatter its bits onto the mask positions.
  task automatic build_exp(input logic [AW-1:0] a, input logic [AW-1:0] m,
                           input int xo, input int xl, input int yo, input int yl);
    logic [AW-1:0] f, em, base, s;
    int pos[$];
    int n;
    beat_t b;
    f = '0;
    for (int i = 0; i < int'(AW); i++) begin
      if ((i >= xo && i < xo + xl) || (i >= yo && i < yo + yl)) f[i] = 1'b1;
    end
    em   = m & f;
    base = a & ~em;
    for (int i = 0; i < int'(AW); i++) if (em[i]) pos.push_back(i);
    n = 1 << pos.size();
    for (int k = 0; k < n; k++) begin
      s = '0;
      for (int j = 0; j < pos.size(); j++) if (k[j]) s[pos[j]] = 1'b1;
      b.addr = base | s;
      b.idx  = k % (1 << IW);
      b.last = (k == n - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic push_lit(input logic [AW-1:0] a, input int idx, input bit last);
    beat_t b;
    b.addr = a;
    b.idx  = idx;
    b.last = last;
    exp_q.push_back(b);
  endtask

  // Present a request for one edge, then scramble the inputs to prove they are not re-sampled.
  task automatic issue(input logic [AW-1:0] a, input logic [AW-1:0] m,
                       input int xo, input int xl, input int yo, input int yl);
    req_addr  = a;
    req_mask  = m;
    x_off     = SW'(xo);
    x_len     = SW'(xl);
    y_off     = SW'(yo);
    y_len     = SW'(yl);
    req_valid = 1'b1;
    check("req_ready_idle", req_ready, 1);
    step();
    req_valid = 1'b0;
    req_addr  = {$urandom(), $urandom()};
    req_mask  = {$urandom(), $urandom()};
    x_off     = SW'($urandom());
    x_len     = SW'($urandom());
    y_off     = SW'($urandom());
    y_len     = SW'($urandom());
  endtask

  // mode 0: ready always high; 1: random ready; 2: ready pattern 1,0,0,1,0,0,...
  task automatic drain(input int mode);
    int beat = 0;
    int cyc = 0;
    int n = exp_q.size();
    while (beat < n && cyc < n * 8 + 20) begin
      if (mode == 0)      dst_ready = 1'b1;
      else if (mode == 1) dst_ready = ($urandom_range(0, 3) != 0);
      else                dst_ready = (cyc % 3 == 0);
      check("dst_valid", dst_valid, 1);
      check("dst_addr", dst_addr, exp_q[beat].addr);
      check("dst_idx", dst_idx, 64'(exp_q[beat].idx));
      check("dst_last", dst_last, exp_q[beat].last);
      check("busy", busy, 1);
      check("req_ready_busy", req_ready, 0);
      step();
      cyc++;
      if (dst_ready) beat++;
    end
    if (beat < n) check("drain_timeout", 64'(beat), 64'(n));
    dst_ready = 1'b0;
    check("gap_valid", dst_valid, 0);
    check("gap_req_ready", req_ready, 1);
    check("gap_busy", busy, 0);
    exp_q.delete();
  endtask

  task automatic push_scn1();
    logic [AW-1:0] lit[8];
    lit = '{48'h2000_1234, 48'h2004_1234, 48'h2010_1234, 48'h2014_1234,
            48'h2020_1234, 48'h2024_1234, 48'h2030_1234, 48'h2034_1234};
    for (int i = 0; i < 8; i++) push_lit(lit[i], i, i == 7);
  endtask

  initial begin
    logic [AW-1:0] a, m;
    int xo, xl, yo, yl;

    step();
    step();
    check("rst_req_ready", req_ready, 1);
    check("rst_dst_valid", dst_valid, 0);
    check("rst_dst_addr", dst_addr, 0);
    check("rst_dst_idx", dst_idx, 0);
    check("rst_dst_last", dst_last, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    step();

    // Basic 8-way unroll
    push_scn1();
    issue(48'h2000_1234, 48'h0034_0000, 20, 2, 18, 2);
    drain(0);

    // Base bits under the mask cleared, out-of-field mask bits ignored
    push_lit(48'h2000_0000, 0, 1'b0);
    push_lit(48'h2010_0000, 1, 1'b1);
    issue(48'h2010_0000, 48'h0010_00FF, 20, 2, 18, 2);
    drain(0);

    // Zero effective mask
    push_lit(48'h1234_5678_9ABC, 0, 1'b1);
    issue(48'h1234_5678_9ABC, 48'h0, 20, 2, 18, 2);
    drain(0);

    // Backpressure
    push_scn1();
    issue(48'h2000_1234, 48'h0034_0000, 20, 2, 18, 2);
    drain(2);

    // Reset after beat 3
    push_scn1();
    issue(48'h2000_1234, 48'h0034_0000, 20, 2, 18, 2);
    dst_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("pre_rst_addr", dst_addr, exp_q[k].addr);
      step();
    end
    exp_q.delete();
    dst_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_valid", dst_valid, 0);
    check("mid_rst_addr", dst_addr, 0);
    check("mid_rst_idx", dst_idx, 0);
    check("mid_rst_last", dst_last, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_req_ready", req_ready, 1);
    build_exp(48'hABCD_0000_1111, 48'h0000_000F_0000, 16, 2, 18, 2);
    issue(48'hABCD_0000_1111, 48'h0000_000F_0000, 16, 2, 18, 2);
    drain(1);

    // Back-to-back: second request held valid during the first unroll
    push_scn1();
    issue(48'h2000_1234, 48'h0034_0000, 20, 2, 18, 2);
    req_addr  = 48'h2010_0000;
    req_mask  = 48'h0010_00FF;
    x_off     = SW'(20);
    x_len     = SW'(2);
    y_off     = SW'(18);
    y_len     = SW'(2);
    req_valid = 1'b1;
    drain(0);
    push_lit(48'h2000_0000, 0, 1'b0);
    push_lit(48'h2010_0000, 1, 1'b1);
    issue(48'h2010_0000, 48'h0010_00FF, 20, 2, 18, 2);
    drain(0);

    // Beat index wraps past 2^IW - 1
    build_exp(48'h5555_0000_0000, 48'h1FFF, 0, 13, 0, 0);
    issue(48'h5555_0000_0000, 48'h1FFF, 0, 13, 0, 0);
    drain(0);

    // Random requests, including fields that spill past AddrWidth
    for (int r = 0; r < 24; r++) begin
      a  = {$urandom(), $urandom()};
      m  = {$urandom(), $urandom()};
      xo = $urandom_range(0, 63);
      xl = $urandom_range(0, 4);
      yo = $urandom_range(0, 63);
      yl = $urandom_range(0, 4);
      build_exp(a, m, xo, xl, yo, yl);
      issue(a, m, xo, xl, yo, yl);
      drain($urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
